ex_hazard_ctrl: RTL and testbench

Pipeline hazard and redirect controller driving hold/flush strobes into the IF/ID, ID/EX (ex_control_pipe and its datapath twin) and EX/MEM registers. It consumes the control fields already latched into EX (ALUOp, Jump, J_Jump, MemRead) plus ID source register numbers. It resolves three events:
- load-use stalls
- multi-cycle multiply stalls (FSM plus down-counter)
- EX-stage jump/branch redirects that squash younger instructions

---
 rtl/ex_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard/redirect controller: load-use stalls, multi-cycle multiply stalls
// and jump/branch squashes. Define HAZARD_STATS_EN to add saturating event counters.
module ex_hazard_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter logic [3:0]  MUL_ALUOP   = 4'b1011,
  parameter int unsigned REG_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [3:0]       ex_ALUOp,
  input  logic [1:0]       ex_Jump,
  input  logic             ex_J_Jump,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             idex_hold,
  output logic             exmem_bubble,
  output logic             busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stat_stall_cycles,
  output logic [31:0]      stat_flushes,
  output logic [31:0]      stat_mul_ops
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 2);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic redirect_hit, mul_hit, load_use_hit;
  logic redirect_evt, mul_evt;

  // Raw event decode from the EX control fields; a bubble in EX masks everything.
  always_comb begin
    redirect_hit = ex_valid & ((ex_Jump != 2'b00) | ex_J_Jump);
    mul_hit      = ex_valid & (ex_ALUOp == MUL_ALUOP);
    load_use_hit = ex_valid & ex_mem_read & (ex_rt != '0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and strobe generation; one event acted on per cycle.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    idex_hold    = 1'b0;
    exmem_bubble = 1'b0;
    busy         = 1'b0;
    redirect_evt = 1'b0;
    mul_evt      = 1'b0;

    if (reset) begin
      state_next   = RUN;
      cnt_next     = '0;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (redirect_hit) begin
            // Squash the two younger instructions sitting in IF/ID and ID/EX.
            redirect_evt = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
          end else if (mul_hit) begin
            mul_evt      = 1'b1;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            state_next   = MUL_WAIT;
            cnt_next     = MUL_LOAD;
          end else if (load_use_hit) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_flush   = 1'b1;
          end
        end
        MUL_WAIT: begin
          busy = 1'b1;
          if (cnt != '0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            cnt_next     = cnt - CNT_W'(1);
          end else begin
            // Final multiply cycle: release the pipeline on this edge.
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cycles <= '0;
      stat_flushes      <= '0;
      stat_mul_ops      <= '0;
    end else begin
      if (!pc_write && (stat_stall_cycles != 32'hFFFF_FFFF))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (redirect_evt && (stat_flushes != 32'hFFFF_FFFF))
        stat_flushes <= stat_flushes + 32'd1;
      if (mul_evt && (stat_mul_ops != 32'hFFFF_FFFF))
        stat_mul_ops <= stat_mul_ops + 32'd1;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = redirect_evt ^ mul_evt;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed self-checking bench for ex_hazard_ctrl (MUL_LATENCY 4 and 2 instances).
module tb_ex_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  // {pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_bubble, busy}
  localparam logic [6:0] RSTV  = 7'b0011010;
  localparam logic [6:0] DEF   = 7'b1100000;
  localparam logic [6:0] DEFB  = 7'b1100001;
  localparam logic [6:0] LU    = 7'b0001000;
  localparam logic [6:0] MULS  = 7'b0000110;
  localparam logic [6:0] MULW  = 7'b0000111;
  localparam logic [6:0] REDIR = 7'b1111000;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_valid, ex_mem_read, ex_J_Jump;
  logic [3:0]       ex_ALUOp;
  logic [1:0]       ex_Jump;

  logic pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_bubble, busy;
  logic pc_write2, ifid_write2, ifid_flush2, idex_flush2, idex_hold2, exmem_bubble2, busy2;
  logic [6:0] outs, outs2;

  int checks = 0;
  int errors = 0;

`ifdef HAZARD_STATS_EN
  logic [31:0] s_stall, s_flush, s_mul, s_stall2, s_flush2, s_mul2;
`endif

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.MUL_LATENCY(4), .MUL_ALUOP(4'b1011), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_ALUOp(ex_ALUOp),
    .ex_Jump(ex_Jump), .ex_J_Jump(ex_J_Jump), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .idex_hold(idex_hold),
    .exmem_bubble(exmem_bubble), .busy(busy)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cycles(s_stall), .stat_flushes(s_flush), .stat_mul_ops(s_mul)
`endif
  );

  ex_hazard_ctrl #(.MUL_LATENCY(2), .MUL_ALUOP(4'b1011), .REG_W(REG_W)) dut2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_ALUOp(ex_ALUOp),
    .ex_Jump(ex_Jump), .ex_J_Jump(ex_J_Jump), .pc_write(pc_write2), .ifid_write(ifid_write2),
    .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .idex_hold(idex_hold2),
    .exmem_bubble(exmem_bubble2), .busy(busy2)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cycles(s_stall2), .stat_flushes(s_flush2), .stat_mul_ops(s_mul2)
`endif
  );

  assign outs  = {pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_bubble, busy};
  assign outs2 = {pc_write2, ifid_write2, ifid_flush2, idex_flush2, idex_hold2, exmem_bubble2, busy2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rt = '0; ex_ALUOp = 4'd0;
    ex_Jump = 2'b00; ex_J_Jump = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== RSTV) begin
        errors++; $display("FAIL reset_hold[%0d] got %b exp %b", i, outs, RSTV);
      end
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL reset_release got %b exp %b", outs, DEF); end
    tick();
  endtask

  task automatic test_load_use();
    // ex_rt==id_rs: one stall cycle, then load has moved on
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd7;
    @(negedge clk);
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL lu_rs got %b exp %b", outs, LU); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL lu_after got %b exp %b", outs, DEF); end
    tick();
    // ex_rt==0 never stalls
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rt = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL lu_r0 got %b exp %b", outs, DEF); end
    tick();
    // rt match but ID does not read rt
    ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL lu_rt_unused got %b exp %b", outs, DEF); end
    tick();
    id_uses_rt = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL lu_rt_used got %b exp %b", outs, LU); end
    tick();
    // not a load
    ex_mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL lu_noload got %b exp %b", outs, DEF); end
    tick();
    // bubble in EX masks the match
    ex_mem_read = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL lu_bubble got %b exp %b", outs, DEF); end
    tick();
    idle();
  endtask

  task automatic test_mul();
    // cycle 1: both instances enter
    ex_valid = 1'b1; ex_ALUOp = 4'b1011;
    @(negedge clk);
    checks++;
    if (outs !== MULS) begin errors++; $display("FAIL mul4_c1 got %b exp %b", outs, MULS); end
    checks++;
    if (outs2 !== MULS) begin errors++; $display("FAIL mul2_c1 got %b exp %b", outs2, MULS); end
    tick();
    // cycle 2: jump in EX must be ignored while waiting
    ex_Jump = 2'b01;
    @(negedge clk);
    checks++;
    if (outs !== MULW) begin errors++; $display("FAIL mul4_c2 got %b exp %b", outs, MULW); end
    checks++;
    if (outs2 !== DEFB) begin errors++; $display("FAIL mul2_c2 got %b exp %b", outs2, DEFB); end
    tick();
    // cycle 3: L=2 instance back in RUN sees a second multiply
    ex_Jump = 2'b00;
    @(negedge clk);
    checks++;
    if (outs !== MULW) begin errors++; $display("FAIL mul4_c3 got %b exp %b", outs, MULW); end
    checks++;
    if (outs2 !== MULS) begin errors++; $display("FAIL mul2_b2b got %b exp %b", outs2, MULS); end
    tick();
    @(negedge clk);
    checks++;
    if (outs !== DEFB) begin errors++; $display("FAIL mul4_c4 got %b exp %b", outs, DEFB); end
    checks++;
    if (outs2 !== DEFB) begin errors++; $display("FAIL mul2_b2b_end got %b exp %b", outs2, DEFB); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL mul4_c5 got %b exp %b", outs, DEF); end
    tick();
  endtask

  task automatic test_redirect();
    ex_valid = 1'b1; ex_Jump = 2'b01;
    @(negedge clk);
    checks++;
    if (outs !== REDIR) begin errors++; $display("FAIL redir_jump got %b exp %b", outs, REDIR); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL redir_after got %b exp %b", outs, DEF); end
    tick();
    ex_valid = 1'b1; ex_J_Jump = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== REDIR) begin errors++; $display("FAIL redir_jj got %b exp %b", outs, REDIR); end
    tick();
    ex_valid = 1'b0; ex_J_Jump = 1'b0; ex_Jump = 2'b10;
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL redir_bubble got %b exp %b", outs, DEF); end
    tick();
    idle();
  endtask

  task automatic test_priority();
    // redirect beats load-use
    ex_valid = 1'b1; ex_Jump = 2'b10; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    @(negedge clk);
    checks++;
    if (outs !== REDIR) begin errors++; $display("FAIL pri_jump_load got %b exp %b", outs, REDIR); end
    tick();
    // multiply beats load-use
    ex_Jump = 2'b00; ex_ALUOp = 4'b1011;
    @(negedge clk);
    checks++;
    if (outs !== MULS) begin errors++; $display("FAIL pri_mul_load got %b exp %b", outs, MULS); end
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL pri_drain got %b exp %b", outs, DEF); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    ex_valid = 1'b1; ex_ALUOp = 4'b1011;
    tick();
    idle();
    tick();
    // now in MUL_WAIT with counter 1
    @(negedge clk);
    checks++;
    if (outs !== MULW) begin errors++; $display("FAIL midmul_pre got %b exp %b", outs, MULW); end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== RSTV) begin errors++; $display("FAIL midmul_rst0 got %b exp %b", outs, RSTV); end
    tick();
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== RSTV) begin errors++; $display("FAIL midmul_rst[%0d] got %b exp %b", i, outs, RSTV); end
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== DEF) begin errors++; $display("FAIL midmul_release got %b exp %b", outs, DEF); end
    tick();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    reset = 1'b1; idle();
    tick(); tick();
    reset = 1'b0;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    tick();
    idle(); tick();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd6; id_rt = 5'd6; id_uses_rt = 1'b1;
    tick();
    idle();
    ex_valid = 1'b1; ex_ALUOp = 4'b1011;
    tick();
    idle();
    tick(); tick(); tick();
    ex_valid = 1'b1; ex_Jump = 2'b01;
    tick();
    idle(); tick();
    @(negedge clk);
    checks++;
    if (s_stall !== 32'd5) begin errors++; $display("FAIL stat_stall got %0d exp 5", s_stall); end
    checks++;
    if (s_flush !== 32'd1) begin errors++; $display("FAIL stat_flush got %0d exp 1", s_flush); end
    checks++;
    if (s_mul !== 32'd1) begin errors++; $display("FAIL stat_mul got %0d exp 1", s_mul); end
    tick();
  endtask
`endif

  initial begin
    idle();
    reset = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_mul();
    test_redirect();
    test_priority();
    test_reset_mid_mul();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
